mining_job_dispatcher: RTL
==========================

// Module: mining_job_dispatcher
// PURPOSE
//  Host-side counterpart of the SHA-256 miner's UART link. Holds a 32-word (128-byte) job,
//  streams it byte-by-byte into a UART transmitter, then collects the LSB-first result
//  hash bytes the miner sends back. Sits between the job source and the uart byte interface.
// PARAMETERS
//  WORDS      32      job length in 32-bit words (128 bytes)
//  HASH_BYTES 32      max result bytes (256-bit hash)
//  GAP_CYC    100000  idle cycles after the last rx byte that end collection
//  TMO_CYC    2**28   cycles waiting for the first rx byte (only with MINING_JOB_TIMEOUT_EN)
// PORTS
//  clk_i      in  1    system clock
//  rst_i      in  1    reset, synchronous, active-high
//  job_we_i   in  1    job word write strobe
//  job_addr_i in  5    job word index 0..31
//  job_data_i in  32   job word
//  start_i    in  1    start send+collect (pulse)
//  busy_o     out 1    high from start acceptance until done_o
//  tx_valid_o out 1    byte available for uart tx
//  tx_data_o  out 8    tx byte
//  tx_ready_i in  1    uart tx accepts byte
//  rx_valid_i in  1    rx byte strobe (1 cycle)
//  rx_data_i  in  8    rx byte
//  done_o     out 1    1-cycle pulse, result valid
//  hash_o     out 256  assembled result hash
//  nbytes_o   out 6    result bytes received 0..32
//  timeout_o  out 1    collection ended by TMO_CYC with 0 bytes
// BEHAVIOUR
//  - Reset: state IDLE; busy_o, tx_valid_o, done_o, timeout_o = 0; hash_o = 0; nbytes_o = 0;
//    tx_data_o = 0. Job buffer is not reset; contents are retained across rst_i.
//  - Job writes accepted only in IDLE; ignored while busy_o=1. start_i ignored while busy_o=1.
//  - FSM: IDLE -start_i-> SEND -last byte accepted-> WAIT -first rx-> COLLECT
//         -32nd byte | gap expiry-> DONE -> IDLE (DONE lasts exactly 1 cycle, done_o=1).
//  - start accepted: busy_o=1 next cycle; hash_o, nbytes_o, timeout_o cleared.
//  - SEND order: word 0..31, each word MSB byte first (byte[31:24] first). 128 bytes total.
//  - Handshake: transfer when tx_valid_o&tx_ready_i; tx_data_o/tx_valid_o stable while
//    valid&~ready; next byte presented the cycle after a transfer (no bubble required).
//  - First tx_valid_o asserts 1 cycle after start acceptance.
//  - rx bytes arriving in IDLE or SEND are discarded.
//  - COLLECT: byte k (0-based) written to hash_o[8k+7:8k]; unreceived upper bytes stay 0
//    (miner stops once remaining shifted hash is zero). nbytes_o increments per byte.
//  - Gap counter resets on every rx byte; expiry after GAP_CYC idle cycles -> DONE.
//    rx byte in same cycle as expiry: byte stored, counter restarts, no DONE.
//  - After 32nd byte -> DONE next cycle; further rx ignored until next start.
//  - rst_i mid-operation: abort to IDLE in next cycle, no done_o pulse.
//  - Counters: byte index 7b, wraps never (terminates at 127); gap/tmo counters saturate.
// CONFIGURATION
//  MINING_JOB_TIMEOUT_EN defined: in WAIT, TMO_CYC cycles without rx -> DONE with
//    timeout_o=1, nbytes_o=0, hash_o=0. timeout_o held until next start.
//  Undefined: WAIT waits indefinitely (only rst_i exits); timeout_o tied 0.
// STRUCTURE
//  Package mining_pkg: typedef enum logic[2:0] {IDLE,SEND,WAIT,COLLECT,DONE} disp_state_t;
//    localparams JOB_BYTES=128, HASH_W=256, byte_t typedef.
//  Sub-module result_collector: COLLECT datapath (hash assembly, nbytes, gap counter,
//    gap_expired/full flags). FSM, job RAM and tx serializer stay in the top.
// TESTING
//  1 Write words w[k]=32'h0A0B0C00+k, start, tx_ready_i=1 -> 128 bytes, first 0A,0B,0C,00,
//    last 0A,0B,0C,1F; exactly 128 transfers.
//  2 Random tx_ready_i stalls -> tx_data_o stable during stall, same 128-byte sequence.
//  3 Send 32 rx bytes 8'h01..8'h20 -> done_o 1 cycle after 32nd, hash_o[7:0]=01,
//    hash_o[255:248]=20, nbytes_o=32; 33rd byte ignored.
//  4 Send 3 bytes AA,BB,CC then silence -> done_o after GAP_CYC idle, hash_o=256'hCCBBAA,
//    nbytes_o=3; byte at expiry cycle extends collection.
//  5 rst_i during SEND byte 50 -> tx_valid_o=0, busy_o=0 next cycle; new start resends byte 0.
//  6 MINING_JOB_TIMEOUT_EN, no rx -> done_o & timeout_o=1 after TMO_CYC; undefined: busy_o stays 1.

Source files
------------

// File: rtl/mining_job_dispatcher_pkg.sv
// Shared types and constants for the mining job dispatcher.
// Optional feature macro used by the top: MINING_JOB_TIMEOUT_EN.
package mining_pkg;

  localparam int JOB_BYTES = 128;
  localparam int HASH_W    = 256;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT    = 3'd2,
    COLLECT = 3'd3,
    DONE    = 3'd4
  } disp_state_t;

  // Job words go out MSB byte first: lane 0 is bits [31:24].
  function automatic byte_t job_byte(input logic [31:0] word, input logic [1:0] lane);
    byte_t b;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mining_job_dispatcher_result_collector.sv
// Result collector: assembles the LSB-first hash bytes returned by the miner,
// counts them, and tracks the idle gap that ends a short result.
module result_collector
  import mining_pkg::*;
#(
  parameter int HASH_BYTES = 32,
  parameter int GAP_CYC    = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    capture,
  input  logic                    gap_run,
  input  byte_t                   rx_byte,
  output logic [8*HASH_BYTES-1:0] hash,
  output logic [5:0]              nbytes,
  output logic                    last_byte,
  output logic                    full,
  output logic                    gap_expired
);

  localparam int GAP_W = $clog2(GAP_CYC + 1);

  logic [GAP_W-1:0] gap_cnt;

  // The capture that fills the final hash byte ends collection immediately.
  assign last_byte = capture && (nbytes == 6'(HASH_BYTES - 1));
  assign full      = (nbytes == 6'(HASH_BYTES));

  // Expiry only counts truly idle cycles; a byte landing on the expiry cycle wins.
  assign gap_expired = gap_run && !capture && (gap_cnt >= GAP_W'(GAP_CYC - 1));

  // Store each incoming byte at the next free byte lane and bump the count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hash   <= '0;
      nbytes <= '0;
    end else if (capture) begin
      for (int k = 0; k < HASH_BYTES; k++) begin
        if (nbytes == 6'(k)) begin
          hash[8*k +: 8] <= rx_byte;
        end
      end
      nbytes <= nbytes + 6'd1;
    end
  end

  // Idle-gap counter: restarts on every byte, saturates so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst || clear || capture) begin
      gap_cnt <= '0;
    end else if (gap_run && (gap_cnt != GAP_W'(GAP_CYC))) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mining_job_dispatcher.sv
// Mining job dispatcher: holds a 32-word job, streams it MSB-byte-first into a
// UART transmitter, then collects the miner's LSB-first result hash.
// Optional feature: define MINING_JOB_TIMEOUT_EN to give up after TMO_CYC
// cycles without a first result byte (timeout_o reports it).
module mining_job_dispatcher
  import mining_pkg::*;
#(
  parameter int WORDS      = 32,
  parameter int HASH_BYTES = 32,
  parameter int GAP_CYC    = 100000
`ifdef MINING_JOB_TIMEOUT_EN
  ,
  parameter int TMO_CYC    = 2**28
`endif
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         job_we_i,
  input  logic [4:0]   job_addr_i,
  input  logic [31:0]  job_data_i,
  input  logic         start_i,
  output logic         busy_o,
  output logic         tx_valid_o,
  output logic [7:0]   tx_data_o,
  input  logic         tx_ready_i,
  input  logic         rx_valid_i,
  input  logic [7:0]   rx_data_i,
  output logic         done_o,
  output logic [255:0] hash_o,
  output logic [5:0]   nbytes_o,
  output logic         timeout_o
);

  localparam logic [6:0] LAST_IDX = 7'(4 * WORDS - 1);

  disp_state_t state;
  logic [31:0] job_mem [WORDS];
  logic [6:0]  byte_idx;
  logic [6:0]  next_idx;
  byte_t       next_byte;
  byte_t       first_byte;
  logic        start_ok;
  logic        tx_fire;
  logic        capture;
  logic        col_last;
  logic        col_full;
  logic        gap_expired;
  logic        tmo_expired;

  assign start_ok   = start_i && (state == IDLE);
  assign tx_fire    = tx_valid_o && tx_ready_i;
  assign next_idx   = byte_idx + 7'd1;
  assign next_byte  = job_byte(job_mem[next_idx[6:2]], next_idx[1:0]);
  assign first_byte = job_byte(job_mem[0], 2'd0);
  assign capture    = rx_valid_i && ((state == WAIT) || (state == COLLECT)) && !col_full;

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  // Job buffer: writable only while idle, deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (job_we_i && (state == IDLE)) begin
      job_mem[job_addr_i] <= job_data_i;
    end
  end

`ifdef MINING_JOB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_q;

  assign tmo_expired = (state == WAIT) && !capture && (tmo_cnt >= TMO_W'(TMO_CYC - 1));
  assign timeout_o   = timeout_q;

  // First-byte watchdog; the timeout flag stays up until the next job starts.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else if (state == WAIT) begin
      if (tmo_cnt != TMO_W'(TMO_CYC)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_expired) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_expired = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  // Main sequencer plus the tx serializer that walks the job byte by byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      byte_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= SEND;
            byte_idx   <= '0;
            tx_valid_o <= 1'b1;
            tx_data_o  <= first_byte;
          end
        end
        SEND: begin
          if (tx_fire) begin
            if (byte_idx == LAST_IDX) begin
              tx_valid_o <= 1'b0;
              state      <= WAIT;
            end else begin
              byte_idx  <= next_idx;
              tx_data_o <= next_byte;
            end
          end
        end
        WAIT: begin
          if (capture) begin
            state <= col_last ? DONE : COLLECT;
          end else if (tmo_expired) begin
            state <= DONE;
          end
        end
        COLLECT: begin
          if (col_last || gap_expired) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  result_collector #(
    .HASH_BYTES (HASH_BYTES),
    .GAP_CYC    (GAP_CYC)
  ) u_collector (
    .clk         (clk_i),
    .rst         (rst_i),
    .clear       (start_ok),
    .capture     (capture),
    .gap_run     (state == COLLECT),
    .rx_byte     (rx_data_i),
    .hash        (hash_o),
    .nbytes      (nbytes_o),
    .last_byte   (col_last),
    .full        (col_full),
    .gap_expired (gap_expired)
  );

endmodule
